uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 175 +++++++++++++++++
 tb/tb_uart_rx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Samples at mid-bit using a down-counting bit timer with terminal-count compare.
module uart_rx #(
    parameter int CLOCK_HZ = 10_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       done_o,
    output logic       busy_o,
    output logic       frame_error_o,
    output logic       parity_error_o
);

    localparam int TICKS = (CLOCK_HZ + BAUD / 2) / BAUD;
    localparam int CW    = $clog2(TICKS) + 1;

    // Counter expires on zero, so a load of N gives N+1 cycles to the next sample.
    localparam logic [CW-1:0] HALF_LOAD = CW'(TICKS / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(TICKS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
    logic            perr_q, perr_d;
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    logic            cnt_zero;
    logic            par_bad;
`ifdef UART_RX_PARITY_EN
    logic            par_bad_q, par_bad_d;
`endif

    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) par_bad_q <= 1'b0;
        else         par_bad_q <= par_bad_d;
    end
    assign par_bad = par_bad_q;
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: begin
                if (cnt_zero) begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (!rx_sync_q) begin
                        state_d = DATA;
                        cnt_d   = FULL_LOAD;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DATA: begin
                if (cnt_zero) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    cnt_d   = FULL_LOAD;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_zero) begin
                    par_bad_d = rx_sync_q ^ (^shift_q);
                    state_d   = STOP;
                    cnt_d     = FULL_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                    perr_d  = par_bad;
                    if (!rx_sync_q) begin
                        ferr_d = 1'b1;
                    end else if (!par_bad) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_o         = data_q;
    assign done_o         = done_q;
    assign busy_o         = (state_q != IDLE);
    assign frame_error_o  = ferr_q;
    assign parity_error_o = perr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame table, latency, glitch, reset-abort and
// (with UART_RX_PARITY_EN) parity sequences.
module tb_uart_rx;

    localparam int TICKS = 87;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       done, busy, ferr, perr;

    int total = 0;
    int bad   = 0;

    int done_cnt = 0, ferr_cnt = 0, perr_cnt = 0, wide_cnt = 0, both_cnt = 0;
    logic prev_done = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0;

    uart_rx #(.CLOCK_HZ(10_000_000), .BAUD(115200)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .rx_i           (rx),
        .data_o         (data),
        .done_o         (done),
        .busy_o         (busy),
        .frame_error_o  (ferr),
        .parity_error_o (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (ferr) ferr_cnt++;
        if (perr) perr_cnt++;
        if ((done && prev_done) || (ferr && prev_ferr) || (perr && prev_perr)) wide_cnt++;
        if (done && ferr) both_cnt++;
        prev_done = done;
        prev_ferr = ferr;
        prev_perr = perr;
    end

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         gap;
        int         exp_done;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (TICKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ bad_par);
`else
        if (bad_par) rx = 1'b1;
`endif
        send_bit(stop);
    endtask

    initial begin
        int d0, f0, p0, cycles;

        vecs[0] = '{8'hF0, 1'b1,   0, 1, 0, 8'hF0};
        vecs[1] = '{8'h31, 1'b1, 100, 1, 0, 8'h31};
        vecs[2] = '{8'h55, 1'b0, 100, 0, 1, 8'h31};
        vecs[3] = '{8'h00, 1'b1,  50, 1, 0, 8'h00};
        vecs[4] = '{8'hFF, 1'b1,  50, 1, 0, 8'hFF};
        vecs[5] = '{8'h80, 1'b1,   0, 1, 0, 8'h80};
        vecs[6] = '{8'h01, 1'b1,  50, 1, 0, 8'h01};
        vecs[7] = '{8'hA5, 1'b0, 100, 0, 1, 8'h01};

        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_data", data, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ferr", ferr, 0);
        chk("reset_perr", perr, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Start edge to Done: about 43.5 + 9*87 clocks plus synchronizer delay.
        cycles = 0;
        fork
            send_frame(8'hC3, 1'b0, 1'b1);
            begin
                while (!done && cycles < 2000) begin
                    @(negedge clk);
                    cycles++;
                end
            end
        join
        chk("latency_window", int'(cycles >= 824 && cycles <= 830), 1);
        chk("latency_data", data, 8'hC3);
        repeat (100) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
            send_frame(vecs[v].d, 1'b0, vecs[v].stop);
            rx = 1'b1;
            repeat (vecs[v].gap) @(negedge clk);
            chk($sformatf("vec%0d_done", v), done_cnt - d0, vecs[v].exp_done);
            chk($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
            chk($sformatf("vec%0d_perr", v), perr_cnt - p0, 0);
            chk($sformatf("vec%0d_data", v), data, vecs[v].exp_data);
        end

        d0 = done_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (150) @(negedge clk);
        chk("glitch_done", done_cnt - d0, 0);
        chk("glitch_ferr", ferr_cnt - f0, 0);
        chk("glitch_data", data, 8'h01);
        chk("glitch_busy", busy, 0);

        d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'((8'hA5 >> i) & 8'h01));
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_data", data, 0);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ferr", ferr, 0);
        chk("midrst_perr", perr, 0);
        rx = 1'b1;
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("abort_no_strobe", (done_cnt - d0) + (ferr_cnt - f0) + (perr_cnt - p0), 0);
        send_frame(8'h3C, 1'b0, 1'b1);
        rx = 1'b1;
        repeat (50) @(negedge clk);
        chk("after_rst_done", done_cnt - d0, 1);
        chk("after_rst_data", data, 8'h3C);

`ifdef UART_RX_PARITY_EN
        d0 = done_cnt; p0 = perr_cnt;
        send_frame(8'h31, 1'b0, 1'b1);
        repeat (50) @(negedge clk);
        chk("par_good_done", done_cnt - d0, 1);
        chk("par_good_perr", perr_cnt - p0, 0);
        chk("par_good_data", data, 8'h31);
        d0 = done_cnt; p0 = perr_cnt;
        send_frame(8'h31, 1'b1, 1'b1);
        repeat (50) @(negedge clk);
        chk("par_bad_done", done_cnt - d0, 0);
        chk("par_bad_perr", perr_cnt - p0, 1);
        chk("par_bad_data", data, 8'h31);
`else
        chk("no_parity_strobes", perr_cnt, 0);
`endif

        chk("strobe_width", wide_cnt, 0);
        chk("done_ferr_overlap", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
